// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//
// Purpose : shared types for the memory-stage port arbiter. These are the
//           access-size encoding understood by the LSU, the arbiter state
//           encoding, and the request bundle layout used for both the CPU
//           and the debug/loader requester.
//
// Contents:
//   LSU_ADDR_W / LSU_DATA_W - native LSU address/data widths
//   mem_size_e              - LSU access size (byte / half / word)
//   arb_state_e             - arbiter ownership state (ARB / LOCK)
//   mem_req_t               - one requester's access bundle
//   req_is_store()          - small helper used by the LSU store-enable path
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  localparam int unsigned LSU_ADDR_W = 12;
  localparam int unsigned LSU_DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } mem_size_e;

  // ARB: the CPU owns the port by default. LOCK: the debug master owns it.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic                  wren;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wdata;
    mem_size_e             size;
    logic                  unsign;
  } mem_req_t;

  // A bundle turns into an LSU store only when its requester holds the grant.
  function automatic logic req_is_store(input mem_req_t req, input logic granted);
    return granted && req.wren;
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose : shares the single LSU data/IO port between the pipeline memory
//           stage (CPU) and a debug/loader master (DBG). The CPU has priority,
//           and a bounded-wait counter forces a DBG grant once a pending DBG
//           request has been refused MAX_WAIT cycles in a row. DBG may lock
//           the port for bursts, and the CPU is stalled while it is locked.
//
// Ports:
//   clk_i, rst_ni        - clock, synchronous active-low reset
//   cpu_req_i .. cpu_unsign_i
//                        - memory-stage access request and its fields
//   cpu_stall_o          - CPU access not performed this cycle
//   cpu_rdata_o          - combinational load data for a granted CPU load
//   dbg_req_i .. dbg_lock_i
//                        - DBG request (held until granted), fields, lock
//   dbg_gnt_o            - DBG access performed this cycle
//   dbg_rvalid_o         - registered response strobe, one cycle after grant
//   dbg_rdata_o          - registered load data (0 for stores)
//   lsu_*_o              - access presented to the LSU
//   lsu_ld_data_i        - LSU combinational read data
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = LSU_ADDR_W,
  parameter int unsigned DATA_W   = LSU_DATA_W,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              cpu_req_i,
  input  logic              cpu_wren_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  mem_size_e         cpu_size_i,
  input  logic              cpu_unsign_i,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_rdata_o,

  input  logic              dbg_req_i,
  input  logic              dbg_wren_i,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  input  logic              dbg_lock_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,

  output logic              lsu_st_en_o,
  output logic [ADDR_W-1:0] lsu_addr_o,
  output logic [DATA_W-1:0] lsu_st_data_o,
  output logic [1:0]        lsu_mask_o,
  output logic              lsu_unsign_o,
  input  logic [DATA_W-1:0] lsu_ld_data_i
);

  localparam int unsigned     WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_e        state_q;
  logic [WAIT_W-1:0] wait_cnt_q;

  logic     wait_expired;
  logic     gnt_dbg;
  logic     gnt_cpu;
  mem_req_t cpu_bus;
  mem_req_t dbg_bus;
  mem_req_t lsu_bus;

  assign wait_expired = (wait_cnt_q == WAIT_MAX);

  // Pack both requesters into the common bundle. DBG accesses are always
  // signed word accesses, so its size/unsign fields are fixed here.
  always_comb begin
    cpu_bus        = '0;
    cpu_bus.wren   = cpu_wren_i;
    cpu_bus.addr   = LSU_ADDR_W'(cpu_addr_i);
    cpu_bus.wdata  = LSU_DATA_W'(cpu_wdata_i);
    cpu_bus.size   = cpu_size_i;
    cpu_bus.unsign = cpu_unsign_i;

    dbg_bus        = '0;
    dbg_bus.wren   = dbg_wren_i;
    dbg_bus.addr   = LSU_ADDR_W'(dbg_addr_i);
    dbg_bus.wdata  = LSU_DATA_W'(dbg_wdata_i);
    dbg_bus.size   = SZ_WORD;
    dbg_bus.unsign = 1'b0;
  end

  // Grant decision. In ARB the CPU wins unless it is idle or DBG has already
  // been refused MAX_WAIT cycles in a row. In LOCK only DBG may use the port;
  // if DBG has nothing to do the port simply idles and the CPU keeps waiting.
  always_comb begin
    gnt_dbg = 1'b0;
    gnt_cpu = 1'b0;
    case (state_q)
      ARB: begin
        gnt_dbg = dbg_req_i && (!cpu_req_i || wait_expired);
        gnt_cpu = cpu_req_i && !gnt_dbg;
      end
      LOCK: begin
        gnt_dbg = dbg_req_i;
        gnt_cpu = 1'b0;
      end
      default: begin
        gnt_dbg = 1'b0;
        gnt_cpu = 1'b0;
      end
    endcase
  end

  assign cpu_stall_o = cpu_req_i && !gnt_cpu;
  assign dbg_gnt_o   = gnt_dbg;
  assign cpu_rdata_o = lsu_ld_data_i;

  // LSU mux. Without any grant the CPU fields stay on the bus so the address
  // path is quiet, but the store enable is only ever raised for the requester
  // that actually holds the grant, so a stalled store cannot leak through.
  always_comb begin
    lsu_bus = gnt_dbg ? dbg_bus : cpu_bus;
  end

  assign lsu_st_en_o   = req_is_store(cpu_bus, gnt_cpu) || req_is_store(dbg_bus, gnt_dbg);
  assign lsu_addr_o    = ADDR_W'(lsu_bus.addr);
  assign lsu_st_data_o = DATA_W'(lsu_bus.wdata);
  assign lsu_mask_o    = lsu_bus.size;
  assign lsu_unsign_o  = lsu_bus.unsign;

  // Ownership FSM, bounded-wait counter and DBG response register.
  // The counter tracks consecutive refusals of the current DBG request and
  // saturates at MAX_WAIT, which is what forces the next DBG grant. The DBG
  // response is captured on the grant cycle and presented one cycle later;
  // reset drops any response that would otherwise still be pending.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ARB;
      wait_cnt_q   <= '0;
      dbg_rvalid_o <= 1'b0;
      dbg_rdata_o  <= '0;
    end else begin
      case (state_q)
        ARB: begin
          if (gnt_dbg && dbg_lock_i) begin
            state_q <= LOCK;
          end
        end
        LOCK: begin
          if (gnt_dbg && !dbg_lock_i) begin
            state_q <= ARB;
          end
        end
        default: begin
          state_q <= ARB;
        end
      endcase

      if (gnt_dbg || !dbg_req_i) begin
        wait_cnt_q <= '0;
      end else if (!wait_expired) begin
        wait_cnt_q <= wait_cnt_q + 1'b1;
      end

      dbg_rvalid_o <= gnt_dbg;
      if (gnt_dbg) begin
        dbg_rdata_o <= dbg_wren_i ? '0 : lsu_ld_data_i;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A small word-addressed memory
// stands in for the LSU. A directed vector table covers the basic CPU, DBG
// and lock-burst behaviour, hand-written sequences cover the starvation bound
// and reset while locked, and a randomized phase runs against an
// ownership/arbitration reference model kept in the bench.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned ADDR_W   = 12;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned MAX_WAIT = 8;

  typedef struct {
    logic              rst_n;
    logic              cpu_req;
    logic              cpu_wren;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    mem_size_e         cpu_size;
    logic              cpu_unsign;
    logic              dbg_req;
    logic              dbg_wren;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_lock;
  } stim_t;

  typedef struct {
    stim_t       in;
    logic        eStall;
    logic        eGnt;
    logic        eStEn;
    logic        eRvalid;
    logic        chkCpu;
    logic [31:0] eCpuRdata;
    logic        chkDbg;
    logic [31:0] eDbgRdata;
  } vec_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              cpu_req_i;
  logic              cpu_wren_i;
  logic [ADDR_W-1:0] cpu_addr_i;
  logic [DATA_W-1:0] cpu_wdata_i;
  mem_size_e         cpu_size_i;
  logic              cpu_unsign_i;
  logic              cpu_stall_o;
  logic [DATA_W-1:0] cpu_rdata_o;
  logic              dbg_req_i;
  logic              dbg_wren_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_lock_i;
  logic              dbg_gnt_o;
  logic              dbg_rvalid_o;
  logic [DATA_W-1:0] dbg_rdata_o;
  logic              lsu_st_en_o;
  logic [ADDR_W-1:0] lsu_addr_o;
  logic [DATA_W-1:0] lsu_st_data_o;
  logic [1:0]        lsu_mask_o;
  logic              lsu_unsign_o;
  logic [DATA_W-1:0] lsu_ld_data_i;

  always #5 clk_i = ~clk_i;

  mem_port_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cpu_req_i    (cpu_req_i),
    .cpu_wren_i   (cpu_wren_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_size_i   (cpu_size_i),
    .cpu_unsign_i (cpu_unsign_i),
    .cpu_stall_o  (cpu_stall_o),
    .cpu_rdata_o  (cpu_rdata_o),
    .dbg_req_i    (dbg_req_i),
    .dbg_wren_i   (dbg_wren_i),
    .dbg_addr_i   (dbg_addr_i),
    .dbg_wdata_i  (dbg_wdata_i),
    .dbg_lock_i   (dbg_lock_i),
    .dbg_gnt_o    (dbg_gnt_o),
    .dbg_rvalid_o (dbg_rvalid_o),
    .dbg_rdata_o  (dbg_rdata_o),
    .lsu_st_en_o  (lsu_st_en_o),
    .lsu_addr_o   (lsu_addr_o),
    .lsu_st_data_o(lsu_st_data_o),
    .lsu_mask_o   (lsu_mask_o),
    .lsu_unsign_o (lsu_unsign_o),
    .lsu_ld_data_i(lsu_ld_data_i)
  );

  // Stand-in LSU: word memory, combinational read, store on the clock edge.
  logic [31:0] lsuMem [1024];
  logic        memClear;

  always @(posedge clk_i) begin
    if (memClear) begin
      for (int i = 0; i < 1024; i++) lsuMem[i] <= '0;
    end else if (lsu_st_en_o) begin
      lsuMem[lsu_addr_o[11:2]] <= lsu_st_data_o;
    end
  end

  assign lsu_ld_data_i = lsuMem[lsu_addr_o[11:2]];

  // Reference model state: who owns the port, how many cycles in a row the
  // current DBG request has been refused, the response due next cycle, and
  // the memory contents as they should be.
  int          passCount  = 0;
  int          checkCount = 0;
  logic [31:0] refMem [1024];
  bit          mLocked;
  int          mDenied;
  bit          mRvalid;
  logic [31:0] mRdata;
  stim_t       curStim;
  bit          eGntDbg;
  bit          eGntCpu;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic stim_t mkStim(input logic cReq, input logic cWr, input logic [11:0] cAddr,
                                   input logic [31:0] cData, input logic dReq, input logic dWr,
                                   input logic [11:0] dAddr, input logic [31:0] dData,
                                   input logic dLock);
    stim_t s;
    s.rst_n      = 1'b1;
    s.cpu_req    = cReq;
    s.cpu_wren   = cWr;
    s.cpu_addr   = cAddr;
    s.cpu_wdata  = cData;
    s.cpu_size   = SZ_WORD;
    s.cpu_unsign = 1'b0;
    s.dbg_req    = dReq;
    s.dbg_wren   = dWr;
    s.dbg_addr   = dAddr;
    s.dbg_wdata  = dData;
    s.dbg_lock   = dLock;
    return s;
  endfunction

  function automatic vec_t mkVec(input stim_t s, input logic st, input logic gn, input logic en,
                                 input logic rv, input logic cc, input logic [31:0] cd,
                                 input logic dc, input logic [31:0] dd);
    vec_t v;
    v.in = s; v.eStall = st; v.eGnt = gn; v.eStEn = en; v.eRvalid = rv;
    v.chkCpu = cc; v.eCpuRdata = cd; v.chkDbg = dc; v.eDbgRdata = dd;
    return v;
  endfunction

  // Drive one cycle of stimulus after the falling edge, work out what the
  // model expects, and leave time for combinational outputs to settle.
  task automatic applyStimulus(input stim_t s);
    @(negedge clk_i);
    rst_ni       = s.rst_n;
    cpu_req_i    = s.cpu_req;
    cpu_wren_i   = s.cpu_wren;
    cpu_addr_i   = s.cpu_addr;
    cpu_wdata_i  = s.cpu_wdata;
    cpu_size_i   = s.cpu_size;
    cpu_unsign_i = s.cpu_unsign;
    dbg_req_i    = s.dbg_req;
    dbg_wren_i   = s.dbg_wren;
    dbg_addr_i   = s.dbg_addr;
    dbg_wdata_i  = s.dbg_wdata;
    dbg_lock_i   = s.dbg_lock;
    curStim      = s;
    if (mLocked) begin
      eGntDbg = s.dbg_req;
      eGntCpu = 1'b0;
    end else begin
      eGntDbg = s.dbg_req && (!s.cpu_req || mDenied >= int'(MAX_WAIT));
      eGntCpu = s.cpu_req && !eGntDbg;
    end
    #2;
  endtask

  // Compare every DUT output against the model, then advance the model by
  // one clock edge.
  task automatic checkOutput();
    stim_t       s;
    logic [11:0] expAddr;
    logic [31:0] expData;
    logic [31:0] loadVal;
    s       = curStim;
    expAddr = eGntDbg ? s.dbg_addr : s.cpu_addr;
    expData = eGntDbg ? s.dbg_wdata : s.cpu_wdata;
    checkValue("cpu_stall", 32'(cpu_stall_o), 32'(s.cpu_req && !eGntCpu));
    checkValue("dbg_gnt", 32'(dbg_gnt_o), 32'(eGntDbg));
    checkValue("lsu_st_en", 32'(lsu_st_en_o),
               32'((eGntCpu && s.cpu_wren) || (eGntDbg && s.dbg_wren)));
    checkValue("lsu_addr", 32'(lsu_addr_o), 32'(expAddr));
    checkValue("lsu_st_data", lsu_st_data_o, expData);
    checkValue("lsu_mask", 32'(lsu_mask_o), eGntDbg ? 32'(SZ_WORD) : 32'(s.cpu_size));
    checkValue("lsu_unsign", 32'(lsu_unsign_o), eGntDbg ? 32'd0 : 32'(s.cpu_unsign));
    checkValue("dbg_rvalid", 32'(dbg_rvalid_o), 32'(mRvalid));
    if (mRvalid) checkValue("dbg_rdata", dbg_rdata_o, mRdata);
    if (eGntCpu && !s.cpu_wren)
      checkValue("cpu_rdata", cpu_rdata_o, refMem[s.cpu_addr[11:2]]);

    loadVal = refMem[s.dbg_addr[11:2]];
    if (eGntCpu && s.cpu_wren) refMem[s.cpu_addr[11:2]] = s.cpu_wdata;
    if (eGntDbg && s.dbg_wren) refMem[s.dbg_addr[11:2]] = s.dbg_wdata;
    mRvalid = eGntDbg;
    if (eGntDbg) mRdata = s.dbg_wren ? 32'd0 : loadVal;
    if (eGntDbg) mLocked = s.dbg_lock;
    mDenied = (s.dbg_req && !eGntDbg) ? mDenied + 1 : 0;
    if (!s.rst_n) begin
      mLocked = 1'b0;
      mDenied = 0;
      mRvalid = 1'b0;
      mRdata  = '0;
    end
  endtask

  task automatic checkTable(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkValue({tag, "_stall"}, 32'(cpu_stall_o), 32'(v.eStall));
    checkValue({tag, "_gnt"}, 32'(dbg_gnt_o), 32'(v.eGnt));
    checkValue({tag, "_st_en"}, 32'(lsu_st_en_o), 32'(v.eStEn));
    checkValue({tag, "_rvalid"}, 32'(dbg_rvalid_o), 32'(v.eRvalid));
    if (v.chkCpu) checkValue({tag, "_cpu_rdata"}, cpu_rdata_o, v.eCpuRdata);
    if (v.chkDbg) checkValue({tag, "_dbg_rdata"}, dbg_rdata_o, v.eDbgRdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t  vecs [15];
    stim_t idle;
    stim_t s;
    bit    cpuHeld;
    bit    dbgHeld;

    idle = mkStim(0, 0, 12'h000, 32'h0, 0, 0, 12'h000, 32'h0, 0);
    vecs[0]  = mkVec(mkStim(1, 1, 12'h020, 32'h12345678, 0, 0, 12'h0, 32'h0, 0), 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[1]  = mkVec(mkStim(1, 1, 12'h010, 32'hDEADBEEF, 0, 0, 12'h0, 32'h0, 0), 0, 0, 1, 0, 0, 0, 0, 0);
    vecs[2]  = mkVec(mkStim(1, 0, 12'h010, 32'h0, 0, 0, 12'h0, 32'h0, 0), 0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mkVec(mkStim(0, 0, 12'h000, 32'h0, 1, 0, 12'h020, 32'h0, 0), 0, 1, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mkVec(idle, 0, 0, 0, 1, 0, 0, 1, 32'h12345678);
    vecs[5]  = mkVec(mkStim(0, 0, 12'h000, 32'h0, 1, 1, 12'h100, 32'h11110000, 1), 0, 1, 1, 0, 0, 0, 0, 0);
    vecs[6]  = mkVec(mkStim(1, 1, 12'h200, 32'h55, 1, 1, 12'h104, 32'h11110004, 1), 1, 1, 1, 1, 0, 0, 1, 32'h0);
    vecs[7]  = mkVec(mkStim(1, 1, 12'h200, 32'h55, 0, 0, 12'h000, 32'h0, 0), 1, 0, 0, 1, 0, 0, 1, 32'h0);
    vecs[8]  = mkVec(mkStim(1, 1, 12'h200, 32'h55, 1, 1, 12'h108, 32'h11110008, 1), 1, 1, 1, 0, 0, 0, 0, 0);
    vecs[9]  = mkVec(mkStim(1, 1, 12'h200, 32'h55, 1, 1, 12'h10C, 32'h1111000C, 0), 1, 1, 1, 1, 0, 0, 1, 32'h0);
    vecs[10] = mkVec(mkStim(1, 1, 12'h200, 32'h55, 0, 0, 12'h000, 32'h0, 0), 0, 0, 1, 1, 0, 0, 1, 32'h0);
    vecs[11] = mkVec(mkStim(1, 0, 12'h100, 32'h0, 0, 0, 12'h0, 32'h0, 0), 0, 0, 0, 0, 1, 32'h11110000, 0, 0);
    vecs[12] = mkVec(mkStim(1, 0, 12'h104, 32'h0, 0, 0, 12'h0, 32'h0, 0), 0, 0, 0, 0, 1, 32'h11110004, 0, 0);
    vecs[13] = mkVec(mkStim(1, 0, 12'h10C, 32'h0, 0, 0, 12'h0, 32'h0, 0), 0, 0, 0, 0, 1, 32'h1111000C, 0, 0);
    vecs[14] = mkVec(mkStim(1, 0, 12'h200, 32'h0, 0, 0, 12'h0, 32'h0, 0), 0, 0, 0, 0, 1, 32'h00000055, 0, 0);

    for (int i = 0; i < 1024; i++) refMem[i] = '0;
    mLocked = 1'b0;
    mDenied = 0;
    mRvalid = 1'b0;
    mRdata  = '0;

    // Power-up: hold reset and clear the stand-in memory before any checks.
    memClear = 1'b1;
    s = idle;
    s.rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      rst_ni = 1'b0;
      cpu_req_i = 0; cpu_wren_i = 0; cpu_addr_i = '0; cpu_wdata_i = '0;
      cpu_size_i = SZ_WORD; cpu_unsign_i = 0;
      dbg_req_i = 0; dbg_wren_i = 0; dbg_addr_i = '0; dbg_wdata_i = '0; dbg_lock_i = 0;
    end
    memClear = 1'b0;

    $display("[TB] reset state");
    applyStimulus(s);
    checkValue("reset_rvalid", 32'(dbg_rvalid_o), 32'd0);
    checkValue("reset_rdata", dbg_rdata_o, 32'd0);
    checkOutput();

    $display("[TB] directed vector table");
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].in);
      checkTable(vecs[i], i);
      checkOutput();
    end

    // Contention: both requesters hold their loads. The CPU keeps the port
    // for MAX_WAIT cycles, then DBG is forced through, then the CPU resumes.
    $display("[TB] contention and starvation bound");
    for (int k = 0; k < int'(MAX_WAIT) + 1; k++) begin
      applyStimulus(mkStim(1, 0, 12'h010, 32'h0, 1, 0, 12'h020, 32'h0, 0));
      checkValue($sformatf("contend%0d_gnt", k), 32'(dbg_gnt_o), (k == int'(MAX_WAIT)) ? 32'd1 : 32'd0);
      checkValue($sformatf("contend%0d_stall", k), 32'(cpu_stall_o), (k == int'(MAX_WAIT)) ? 32'd1 : 32'd0);
      checkOutput();
    end
    applyStimulus(mkStim(1, 0, 12'h010, 32'h0, 0, 0, 12'h000, 32'h0, 0));
    checkValue("contend_after_stall", 32'(cpu_stall_o), 32'd0);
    checkValue("contend_after_rvalid", 32'(dbg_rvalid_o), 32'd1);
    checkValue("contend_after_rdata", dbg_rdata_o, 32'h12345678);
    checkValue("contend_after_cpu_rdata", cpu_rdata_o, 32'hDEADBEEF);
    checkOutput();

    // Reset while DBG holds the lock with a load in flight.
    $display("[TB] reset during lock");
    applyStimulus(mkStim(0, 0, 12'h000, 32'h0, 1, 0, 12'h020, 32'h0, 1));
    checkValue("lockrst_enter_gnt", 32'(dbg_gnt_o), 32'd1);
    checkOutput();
    s = mkStim(1, 0, 12'h010, 32'h0, 1, 0, 12'h020, 32'h0, 1);
    s.rst_n = 1'b0;
    applyStimulus(s);
    checkValue("lockrst_locked_stall", 32'(cpu_stall_o), 32'd1);
    checkOutput();
    applyStimulus(mkStim(1, 0, 12'h010, 32'h0, 0, 0, 12'h000, 32'h0, 0));
    checkValue("lockrst_after_stall", 32'(cpu_stall_o), 32'd0);
    checkValue("lockrst_after_rvalid", 32'(dbg_rvalid_o), 32'd0);
    checkValue("lockrst_after_cpu_rdata", cpu_rdata_o, 32'hDEADBEEF);
    checkOutput();

    // Randomized traffic. Requests that are refused are held unchanged, as
    // the pipeline and the debug master would do.
    $display("[TB] randomized traffic");
    s = idle;
    cpuHeld = 1'b0;
    dbgHeld = 1'b0;
    for (int i = 0; i < 600; i++) begin
      s.rst_n = ($urandom_range(0, 63) != 0);
      if (!cpuHeld) begin
        s.cpu_req    = ($urandom_range(0, 3) != 0);
        s.cpu_wren   = $urandom_range(0, 1) == 1;
        s.cpu_addr   = 12'($urandom_range(0, 63) << 2);
        s.cpu_wdata  = $urandom;
        s.cpu_size   = mem_size_e'($urandom_range(0, 2));
        s.cpu_unsign = $urandom_range(0, 1) == 1;
      end
      if (!dbgHeld) begin
        s.dbg_req   = $urandom_range(0, 1) == 1;
        s.dbg_wren  = $urandom_range(0, 1) == 1;
        s.dbg_addr  = 12'($urandom_range(0, 63) << 2);
        s.dbg_wdata = $urandom;
        s.dbg_lock  = mLocked ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 3) == 0);
      end
      applyStimulus(s);
      cpuHeld = s.cpu_req && !eGntCpu;
      dbgHeld = s.dbg_req && !eGntDbg;
      checkOutput();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single LSU data/IO port between two requesters: the pipeline memory stage (CPU) and a debug/loader master (DBG), e.g. a UART program loader or bench backdoor.
- Sits between the memory stage and the LSU.
- The CPU has priority. A bounded-wait counter guarantees DBG progress.
- A lock mode lets DBG own the port for multi-access bursts; the CPU is stalled while DBG owns the port.

Parameters:
- ADDR_W, 12, LSU address width (LSU decodes addr[11:0]).
- DATA_W, 32, data width.
- MAX_WAIT, 8, maximum consecutive cycles a pending DBG request may be denied (>=1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset
- cpu_req_i  in  1  memory stage has a load or store this cycle
- cpu_wren_i  in  1  CPU store
- cpu_addr_i  in  ADDR_W  CPU address
- cpu_wdata_i  in  DATA_W  CPU store data
- cpu_size_i  in  2  access size, mem_size_e
- cpu_unsign_i  in  1  zero-extend load
- cpu_stall_o  out  1  CPU access not performed this cycle; pipeline holds the memory stage
- cpu_rdata_o  out  DATA_W  load data, combinational, valid when cpu_req_i && !cpu_stall_o
- dbg_req_i  in  1  DBG request; held until granted
- dbg_wren_i  in  1  DBG store
- dbg_addr_i  in  ADDR_W  DBG address
- dbg_wdata_i  in  DATA_W  DBG store data
- dbg_lock_i  in  1  keep ownership after this access
- dbg_gnt_o  out  1  DBG access performed this cycle
- dbg_rvalid_o  out  1  registered response strobe
- dbg_rdata_o  out  DATA_W  registered load data
- lsu_st_en_o  out  1  to LSU st_en_i
- lsu_addr_o  out  ADDR_W  to LSU address
- lsu_st_data_o  out  DATA_W  to LSU store data
- lsu_mask_o  out  2  to LSU mask_i
- lsu_unsign_o  out  1  to LSU unsign
- lsu_ld_data_i  in  DATA_W  LSU load data (combinational read)

Behaviour:
- Interface: one clock, clk_i. Reset rst_ni is synchronous and active-low.
- Reset values:
  - state = ARB, wait_cnt = 0.
  - dbg_rvalid_o = 0, dbg_rdata_o = 0.
  - Combinational outputs follow the idle rule below.
- State machine, two states:
  - ARB: the CPU owns the port by default.
  - LOCK: DBG owns the port.
- Grant rule in ARB:
  - gnt_dbg = dbg_req_i && (!cpu_req_i || wait_cnt == MAX_WAIT).
  - gnt_cpu = cpu_req_i && !gnt_dbg.
- Grant rule in LOCK: gnt_dbg = dbg_req_i and gnt_cpu = 0.
- Transitions:
  - ARB -> LOCK when gnt_dbg && dbg_lock_i.
  - LOCK -> ARB when gnt_dbg && !dbg_lock_i.
  - LOCK with dbg_req_i = 0: stay in LOCK; the port idles and the CPU stays stalled.
- wait_cnt:
  - Increments when dbg_req_i && !gnt_dbg, saturating at MAX_WAIT.
  - Clears on gnt_dbg or when !dbg_req_i.
  - Width is $clog2(MAX_WAIT+1).
- cpu_stall_o = cpu_req_i && !gnt_cpu. It is 0 when cpu_req_i = 0.
- dbg_gnt_o = gnt_dbg.
- LSU mux:
  - Granted requester's fields drive the LSU.
  - DBG accesses are always word size, signed (lsu_mask_o = SZ_WORD, lsu_unsign_o = 0).
  - With no grant: CPU fields are routed to the LSU and lsu_st_en_o = 0.
  - lsu_st_en_o = (gnt_cpu && cpu_wren_i) || (gnt_dbg && dbg_wren_i). A stalled store must never reach the LSU.
- Latency:
  - CPU load data is combinational, in the same cycle as the grant (the memory stage registers it).
  - DBG response comes 1 cycle after the grant. dbg_rvalid_o pulses for 1 cycle, for loads and stores. dbg_rdata_o = captured lsu_ld_data_i for loads, 0 for stores.
- Simultaneous CPU and DBG requests with wait_cnt < MAX_WAIT: the CPU wins and wait_cnt increments.
- Starvation bound: a continuously stalled DBG request is granted no later than cycle MAX_WAIT+1 after it is raised.
- Reset mid-LOCK: returns to ARB. Any pending dbg_rvalid_o is dropped.

Decomposition:
- Shared package riscv_types gains:
  - mem_size_e (SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10).
  - arb_state_e (ARB, LOCK).
  - A mem_req_t struct {wren, addr, wdata, size, unsign} used for both requester bundles.
- No sub-module. The wait counter and FSM are inline. The LSU is instantiated outside, next to this block in the memory stage.

Test Plan:
- CPU only: cpu_req = 1, store 0xDEADBEEF to 0x010, then load 0x010 -> cpu_stall_o = 0 throughout, lsu_st_en_o = 1 on the store cycle, cpu_rdata_o = 0xDEADBEEF on the load cycle.
- DBG only, load from 0x020 holding 0x12345678 -> dbg_gnt_o = 1 in cycle 0, dbg_rvalid_o = 1 and dbg_rdata_o = 0x12345678 in cycle 1, wait_cnt = 0.
- Contention, MAX_WAIT = 8, both requests held -> the CPU is granted 8 cycles. In cycle 9, dbg_gnt_o = 1 and cpu_stall_o = 1. In cycle 10 the CPU is granted again.
- Lock burst: DBG writes 4 words to 0x100..0x10C, dbg_lock_i = 1 except on the last -> cpu_stall_o = 1 for all 4 grant cycles plus any DBG idle gaps; ARB is re-entered after the last write; memory holds all 4 words.
- Stalled store: CPU store while DBG holds LOCK -> lsu_st_en_o driven only by DBG; the CPU store commits only on its grant cycle after unlock.
- Reset asserted in LOCK with a DBG load in flight -> next cycle state = ARB, dbg_rvalid_o = 0, and a CPU request is granted immediately.
